// File: rtl/ohrr_pkg.sv
// Shared types and helpers for the one-hot round-robin arbiter.
// The optional hold timeout is enabled with the macro OHRR_TIMEOUT_EN.
package ohrr_pkg;

    localparam int OHRR_N        = 3;
    localparam int OHRR_MAX_HOLD = 8;

    // Controller states are one-hot so the state bits can be decoded directly.
    typedef enum logic [2:0] {
        IDLE    = 3'b001,
        GRANT   = 3'b010,
        RELEASE = 3'b100
    } state_t;

    // OR of the indices of all set bits; exact for a legal one-hot vector.
    function automatic int onehot_to_idx(input logic [31:0] vec);
        int idx;
        idx = 0;
        for (int i = 0; i < 32; i++) begin
            if (vec[i]) begin
                idx = idx | i;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational rotating-priority picker: the first set req bit at or after
// last+1, wrapping modulo N.
module rr_pick
    import ohrr_pkg::*;
#(
    parameter  int N   = OHRR_N,
    localparam int IDW = $clog2(N)
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] last,
    output logic [IDW-1:0] pick_idx,
    output logic           pick_valid
);

    logic [IDW-1:0] cand [N];

    // cand[k] is the requester with the k-th highest priority this cycle.
    for (genvar gi = 0; gi < N; gi++) begin : g_cand
        assign cand[gi] = IDW'((int'(last) + gi + 1) % N);
    end

    // Scan from lowest priority upward so the highest-priority hit wins.
    always_comb begin
        pick_idx   = '0;
        pick_valid = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[cand[i]]) begin
                pick_idx   = cand[i];
                pick_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ohrr_arbiter.sv
// Round-robin arbiter driving a one-hot shared resource with a mandatory dead
// cycle between owners. Define OHRR_TIMEOUT_EN to add a forced-release timeout.
module ohrr_arbiter
    import ohrr_pkg::*;
#(
    parameter  int N        = OHRR_N,
    parameter  int MAX_HOLD = OHRR_MAX_HOLD,
    localparam int IDW      = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [N-1:0]   req,
    input  logic [N-1:0]   done,
    output logic [N-1:0]   gnt,
    output logic [IDW-1:0] gnt_id,
    output logic           busy,
    output logic           timeout
);

    if (MAX_HOLD < 2) begin : g_bad_hold
        $error("ohrr_arbiter: MAX_HOLD must be at least 2");
    end

    state_t         state_reg, state_next;
    logic [N-1:0]   gnt_reg, gnt_next;
    logic [IDW-1:0] gnt_id_reg, gnt_id_next;
    logic [IDW-1:0] last_reg, last_next;
    logic           busy_reg, busy_next;
    logic           timeout_reg, timeout_next;
    logic [IDW-1:0] pick_idx;
    logic           pick_valid;
    logic           owner_release;
    logic           hold_hit;

    rr_pick #(.N(N)) u_pick (
        .req        (req),
        .last       (last_reg),
        .pick_idx   (pick_idx),
        .pick_valid (pick_valid)
    );

    assign owner_release = done[gnt_id_reg] | ~req[gnt_id_reg];

`ifdef OHRR_TIMEOUT_EN
    localparam int HOLD_W = $clog2(MAX_HOLD) + 1;

    logic [HOLD_W-1:0] hold_reg, hold_next;

    assign hold_hit = (hold_reg == HOLD_W'(MAX_HOLD - 1));

    always_comb begin
        hold_next = hold_reg;
        if (state_reg == IDLE && pick_valid) begin
            hold_next = '0;
        end else if (state_reg == GRANT) begin
            hold_next = hold_reg + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_reg <= '0;
        end else begin
            hold_reg <= hold_next;
        end
    end
`else
    assign hold_hit = 1'b0;
`endif

    always_comb begin
        state_next   = state_reg;
        gnt_next     = gnt_reg;
        gnt_id_next  = gnt_id_reg;
        last_next    = last_reg;
        busy_next    = busy_reg;
        timeout_next = 1'b0;
        case (state_reg)
            IDLE: begin
                if (pick_valid) begin
                    gnt_next    = N'(1) << pick_idx;
                    gnt_id_next = pick_idx;
                    busy_next   = 1'b1;
                    state_next  = GRANT;
                end else begin
                    gnt_next  = '0;
                    busy_next = 1'b0;
                end
            end
            GRANT: begin
                if (owner_release || hold_hit) begin
                    gnt_next     = '0;
                    busy_next    = 1'b0;
                    last_next    = IDW'(onehot_to_idx(32'(gnt_reg)));
                    timeout_next = ~owner_release;
                    state_next   = RELEASE;
                end
            end
            RELEASE: begin
                gnt_next   = '0;
                busy_next  = 1'b0;
                state_next = IDLE;
            end
            default: begin
                gnt_next   = '0;
                busy_next  = 1'b0;
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            gnt_reg     <= '0;
            gnt_id_reg  <= '0;
            last_reg    <= IDW'(N - 1);
            busy_reg    <= 1'b0;
            timeout_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            gnt_reg     <= gnt_next;
            gnt_id_reg  <= gnt_id_next;
            last_reg    <= last_next;
            busy_reg    <= busy_next;
            timeout_reg <= timeout_next;
        end
    end

    assign gnt     = gnt_reg;
    assign gnt_id  = gnt_id_reg;
    assign busy    = busy_reg;
    assign timeout = timeout_reg;

endmodule

// File: tb/tb_ohrr_arbiter.sv
// Directed testbench for ohrr_arbiter (N=3, MAX_HOLD=8); covers the
// OHRR_TIMEOUT_EN build when that macro is defined.
module tb_ohrr_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] req;
    logic [2:0] done;
    logic [2:0] gnt;
    logic [1:0] gnt_id;
    logic       busy;
    logic       timeout;

    int n_cmp = 0;
    int n_err = 0;

    ohrr_arbiter #(.N(3), .MAX_HOLD(8)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .done    (done),
        .gnt     (gnt),
        .gnt_id  (gnt_id),
        .busy    (busy),
        .timeout (timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge and sample 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic [2:0] eg, input logic eb,
                           input logic [1:0] eid, input logic et);
        $display("t=%0t %s req=%b done=%b gnt=%b id=%0d busy=%b to=%b",
                 $time, tag, req, done, gnt, gnt_id, busy, timeout);
        chk({tag, ".gnt"}, 32'(gnt), 32'(eg));
        chk({tag, ".busy"}, 32'(busy), 32'(eb));
        chk({tag, ".id"}, 32'(gnt_id), 32'(eid));
        chk({tag, ".to"}, 32'(timeout), 32'(et));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] fair_gnt [4];
        logic [1:0] fair_id  [4];
        fair_gnt[0] = 3'b100; fair_id[0] = 2'd2;
        fair_gnt[1] = 3'b001; fair_id[1] = 2'd0;
        fair_gnt[2] = 3'b010; fair_id[2] = 2'd1;
        fair_gnt[3] = 3'b100; fair_id[3] = 2'd2;

        // Reset held with requests pending
        rst_n = 1'b0; req = 3'b111; done = 3'b000;
        step(); step();
        chk_out("rst_hold", 3'b000, 1'b0, 2'd0, 1'b0);
        rst_n = 1'b1; req = 3'b000;
        step(); chk_out("idle0", 3'b000, 1'b0, 2'd0, 1'b0);
        step(); chk_out("idle1", 3'b000, 1'b0, 2'd0, 1'b0);

        // Single request and done release
        req = 3'b010;
        step(); chk_out("single_gnt", 3'b010, 1'b1, 2'd1, 1'b0);
        done = 3'b010;
        step(); chk_out("single_rel", 3'b000, 1'b0, 2'd1, 1'b0);
        done = 3'b000; req = 3'b000;
        step(); chk_out("single_idle", 3'b000, 1'b0, 2'd1, 1'b0);
        step(); chk_out("single_idle2", 3'b000, 1'b0, 2'd1, 1'b0);

        // Fairness: last owner was 1, so rotation starts at 2
        req = 3'b111;
        for (int k = 0; k < 4; k++) begin
            step(); chk_out($sformatf("fair%0d_g1", k), fair_gnt[k], 1'b1, fair_id[k], 1'b0);
            step(); chk_out($sformatf("fair%0d_g2", k), fair_gnt[k], 1'b1, fair_id[k], 1'b0);
            done = fair_gnt[k];
            step(); chk_out($sformatf("fair%0d_rel", k), 3'b000, 1'b0, fair_id[k], 1'b0);
            done = 3'b000;
            step(); chk_out($sformatf("fair%0d_idle", k), 3'b000, 1'b0, fair_id[k], 1'b0);
        end

        // Owner 0 withdraws without done
        step(); chk_out("wd_gnt", 3'b001, 1'b1, 2'd0, 1'b0);
        req = 3'b110;
        step(); chk_out("wd_rel", 3'b000, 1'b0, 2'd0, 1'b0);
        step(); chk_out("wd_idle", 3'b000, 1'b0, 2'd0, 1'b0);
        step(); chk_out("wd_next", 3'b010, 1'b1, 2'd1, 1'b0);

        // Stray done from a non-owner is ignored
        done = 3'b100;
        step(); chk_out("stray", 3'b010, 1'b1, 2'd1, 1'b0);
        done = 3'b000;
        step(); chk_out("stray2", 3'b010, 1'b1, 2'd1, 1'b0);

        // done and req drop together: one release
        done = 3'b010; req = 3'b100;
        step(); chk_out("both_rel", 3'b000, 1'b0, 2'd1, 1'b0);
        done = 3'b000;
        step(); chk_out("both_idle", 3'b000, 1'b0, 2'd1, 1'b0);
        step(); chk_out("both_next", 3'b100, 1'b1, 2'd2, 1'b0);

        // done with req still high and no competitor: re-arbitrated to same owner
        done = 3'b100;
        step(); chk_out("rearb_rel", 3'b000, 1'b0, 2'd2, 1'b0);
        done = 3'b000;
        step(); chk_out("rearb_idle", 3'b000, 1'b0, 2'd2, 1'b0);
        step(); chk_out("rearb_gnt", 3'b100, 1'b1, 2'd2, 1'b0);

        // Long hold by requester 0
        req = 3'b001;
        step(); chk_out("hold_rel", 3'b000, 1'b0, 2'd2, 1'b0);
        step(); chk_out("hold_idle", 3'b000, 1'b0, 2'd2, 1'b0);
        step(); chk_out("hold_c1", 3'b001, 1'b1, 2'd0, 1'b0);
`ifdef OHRR_TIMEOUT_EN
        for (int c = 2; c <= 8; c++) begin
            step(); chk_out($sformatf("hold_c%0d", c), 3'b001, 1'b1, 2'd0, 1'b0);
        end
        step(); chk_out("to_pulse", 3'b000, 1'b0, 2'd0, 1'b1);
        step(); chk_out("to_idle", 3'b000, 1'b0, 2'd0, 1'b0);
        step(); chk_out("to_regnt", 3'b001, 1'b1, 2'd0, 1'b0);
`else
        for (int c = 2; c <= 50; c++) begin
            step(); chk_out($sformatf("hold_c%0d", c), 3'b001, 1'b1, 2'd0, 1'b0);
        end
`endif

        // Asynchronous reset mid-GRANT, between edges
        #2 rst_n = 1'b0;
        #1 chk_out("async_rst", 3'b000, 1'b0, 2'd0, 1'b0);
        req = 3'b110;
        step();
        rst_n = 1'b1;
        step(); chk_out("post_rst", 3'b010, 1'b1, 2'd1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
